decoder_3_8_seq_v: RTL and testbench
====================================

Name: decoder_3_8_seq_v

Overview:
- Registered 3-to-8 decoder / grant sequencer. It converts an encoded index into a one-hot grant, then holds that grant for a programmable number of cycles.
- Sits downstream of the 8-to-3 priority encoders. Encoder output is returned to the requester as a timed one-hot grant.
- A valid/ready handshake lets codes queue back-to-back without idle gaps.

Parameters:
- HOLD_CYCLES, 4, cycles each grant is asserted (legal range 1..255).
- CNT_W, 8, width of the internal hold counter; must hold HOLD_CYCLES-1.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous reset, active-high.
- i_code  in  3  encoded index to grant.
- i_valid  in  1  i_code is valid.
- o_ready  out  1  block can accept a code this cycle (combinational).
- i_en  in  1  run enable; 0 pauses an active grant.
- i_abort  in  1  synchronous cancel of the active grant.
- o_onehot  out  8  one-hot grant; bit i_code is set.
- o_active  out  1  a grant is being held (state HOLD).
- o_done  out  1  one-cycle pulse when a grant completes normally.
- o_last_code  out  3  last accepted code.

Behaviour:
- Reset (async, i_rst=1):
  - state=IDLE, counter=0, o_onehot=8'h00, o_active=0, o_done=0, o_last_code=3'b000.
  - Takes effect immediately, mid-grant included; no o_done is issued.
- States: IDLE, HOLD.
- Accept: a code is accepted on a rising edge when i_valid=1 and o_ready=1.
  - On accept: grant register <= 1<<i_code, counter <= HOLD_CYCLES-1, o_last_code <= i_code, state <= HOLD.
- Latency: o_onehot reflects the accepted code on the first cycle after accept.
- o_ready = (state==IDLE) || (state==HOLD && counter==0 && i_en && !i_abort).
- HOLD, i_en=1, i_abort=0:
  - counter>0: counter decrements.
  - counter==0: grant completes and o_done=1 in the next cycle.
  - On completion without a new accept: state <= IDLE, grant cleared.
  - On completion with a same-edge accept: new grant loads directly and stays in HOLD. No zero cycle between grants, and o_done still pulses for the finished grant.
- Grant duration: each grant is visible on o_onehot for exactly HOLD_CYCLES enabled cycles. HOLD_CYCLES=1 gives a single-cycle grant and allows an accept on every cycle.
- Pause (i_en=0 in HOLD):
  - counter frozen, o_onehot forced to 8'h00, o_active stays 1, o_ready=0.
  - Grant resumes with the remaining count once i_en=1.
  - i_en=0 in IDLE does not block accepts; the first held cycle is then paused.
- Abort (i_abort=1 in HOLD): state <= IDLE, grant cleared, counter <= 0, no o_done. Abort takes priority over completion and over i_en. i_abort in IDLE has no effect.
- i_valid with o_ready=0: i_code is ignored. The requester holds i_valid and i_code until accept.
- Output rules:
  - o_onehot is registered, always 0 or exactly one bit set.
  - o_done is registered and 1 for exactly one cycle per normal completion.
  - o_active=1 iff state==HOLD.
- Code value 3'b111 maps to o_onehot=8'h80; all codes are legal.

Test Plan:
- Reset/basic: HOLD_CYCLES=4; reset, then i_code=3'd5 with i_valid=1 for one cycle -> o_onehot=8'h20 for 4 cycles starting 1 cycle after accept, then 8'h00. o_done=1 in the cycle after the last grant cycle; o_last_code=5.
- Back-to-back: hold i_valid=1 and present codes 0 then 7 -> o_onehot=8'h01 x4 then 8'h80 x4 with no gap. o_ready is high only on the last cycle of each grant; o_done pulses twice.
- Pause: during code 2 (8'h04), drive i_en=0 for 3 cycles after 2 grant cycles -> o_onehot=00 x3, o_active=1, then 8'h04 for the remaining 2 cycles. Total visible grant = 4 cycles.
- Abort vs completion: assert i_abort on the counter==0 cycle with i_valid=1 -> no o_done, o_ready=0 that cycle, state IDLE, o_onehot=00. The new code is accepted on the following cycle.
- Async reset mid-grant: assert i_rst between clock edges during a grant of 8'h10 -> all outputs 0 immediately with no clock edge needed. No o_done after release.
- HOLD_CYCLES=1 sweep: codes 0..7 on consecutive cycles with i_valid=1 -> o_onehot walks 01,02,...,80 one per cycle; o_done is high on 8 consecutive cycles.

Source files
------------

// File: rtl/decoder_3_8_seq_v.sv
// =============================================================================
// decoder_3_8_seq_v : registered 3-to-8 decoder that holds a one-hot grant for
// HOLD_CYCLES enabled cycles, with valid/ready intake.          Rev 1.0
// =============================================================================
`default_nettype none

module decoder_3_8_seq_v #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [2:0] i_code,
  input  logic       i_valid,
  output logic       o_ready,
  input  logic       i_en,
  input  logic       i_abort,
  output logic [7:0] o_onehot,
  output logic       o_active,
  output logic       o_done,
  output logic [2:0] o_last_code
);

  localparam logic [0:0]       S_IDLE = 1'b0;
  localparam logic [0:0]       S_HOLD = 1'b1;
  localparam logic [CNT_W-1:0] C_LOAD = CNT_W'(HOLD_CYCLES - 1);

  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_grant;
  logic             r_done;
  logic [2:0]       r_last_code;

  logic [0:0]       w_next_state;
  logic [CNT_W-1:0] w_next_cnt;
  logic [7:0]       w_next_grant;
  logic             w_accept;
  logic             w_complete;

  // State register and the datapath registers that travel with it
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_grant     <= 8'h00;
      r_done      <= 1'b0;
      r_last_code <= 3'b000;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      r_grant <= w_next_grant;
      r_done  <= w_complete;
      if (w_accept) begin
        r_last_code <= i_code;
      end
    end
  end

  // Completion only happens on an enabled, non-aborted last hold cycle
  assign w_complete = (r_state == S_HOLD) && (r_cnt == '0) && i_en && !i_abort;
  assign w_accept   = i_valid && o_ready;

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_next_grant = r_grant;
    if (w_accept) begin
      // Covers both an accept from IDLE and a seamless reload at completion
      w_next_state = S_HOLD;
      w_next_cnt   = C_LOAD;
      w_next_grant = 8'(1) << i_code;
    end else if (r_state == S_HOLD) begin
      if (i_abort) begin
        w_next_state = S_IDLE;
        w_next_cnt   = '0;
        w_next_grant = 8'h00;
      end else if (i_en) begin
        if (r_cnt == '0) begin
          w_next_state = S_IDLE;
          w_next_grant = 8'h00;
        end else begin
          w_next_cnt = r_cnt - 1'b1;
        end
      end
    end
  end

  // Pausing blanks the grant in the same cycle so visible duration stays exact
  always_comb begin
    o_ready     = (r_state == S_IDLE) || w_complete;
    o_active    = (r_state == S_HOLD);
    o_onehot    = ((r_state == S_HOLD) && i_en) ? r_grant : 8'h00;
    o_done      = r_done;
    o_last_code = r_last_code;
  end

endmodule

`default_nettype wire

// File: tb/tb_decoder_3_8_seq_v.sv
// =============================================================================
// tb_decoder_3_8_seq_v : directed scoreboard bench for decoder_3_8_seq_v.
// =============================================================================
`default_nettype none

module tb_decoder_3_8_seq_v;

  logic       clk = 1'b0;
  logic       rst;

  logic [2:0] c4, c1;
  logic       v4, v1, e4, e1, a4, a1;
  logic       rdy4, rdy1, act4, act1, done4, done1;
  logic [7:0] oh4, oh1;
  logic [2:0] last4, last1;

  always #5 clk = ~clk;

  decoder_3_8_seq_v #(.HOLD_CYCLES(4), .CNT_W(8)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_code(c4), .i_valid(v4), .o_ready(rdy4),
    .i_en(e4), .i_abort(a4), .o_onehot(oh4), .o_active(act4),
    .o_done(done4), .o_last_code(last4)
  );

  decoder_3_8_seq_v #(.HOLD_CYCLES(1), .CNT_W(8)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_code(c1), .i_valid(v1), .o_ready(rdy1),
    .i_en(e1), .i_abort(a1), .o_onehot(oh1), .o_active(act1),
    .o_done(done1), .o_last_code(last1)
  );

  typedef struct {
    bit         sel;
    logic [7:0] oh;
    logic       d;
    logic       act;
    logic       rdy;
    logic [2:0] lst;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passed = 0;

  exp_t        e;
  logic [13:0] got, want;

  // Monitor: pops one expected vector per cycle, away from the clock edge
  always @(negedge clk) begin
    if (q.size() > 0) begin
      e    = q.pop_front();
      want = {e.oh, e.d, e.act, e.rdy, e.lst};
      got  = e.sel ? {oh1, done1, act1, rdy1, last1} : {oh4, done4, act4, rdy4, last4};
      checks++;
      if (got === want) passed++;
      else $display("FAIL %s: got oh=%h done=%b act=%b rdy=%b last=%0d, expected oh=%h done=%b act=%b rdy=%b last=%0d",
                    e.nm, got[13:6], got[5], got[4], got[3], got[2:0],
                    want[13:6], want[5], want[4], want[3], want[2:0]);
    end
  end

  task automatic push(input bit sel, input logic [7:0] oh, input logic d,
                      input logic act, input logic rdy, input logic [2:0] lst,
                      input string nm);
    exp_t x;
    x.sel = sel; x.oh = oh; x.d = d; x.act = act; x.rdy = rdy; x.lst = lst; x.nm = nm;
    q.push_back(x);
  endtask

  // One cycle of stimulus on the selected DUT plus its expected outputs
  task automatic cyc(input bit sel, input logic v, input logic [2:0] c,
                     input logic en, input logic ab, input logic [7:0] oh,
                     input logic d, input logic act, input logic rdy,
                     input logic [2:0] lst, input string nm);
    @(posedge clk);
    #1;
    if (sel) begin
      v1 = v; c1 = c; e1 = en; a1 = ab;
      v4 = 1'b0; c4 = 3'd0; e4 = 1'b1; a4 = 1'b0;
    end else begin
      v4 = v; c4 = c; e4 = en; a4 = ab;
      v1 = 1'b0; c1 = 3'd0; e1 = 1'b1; a1 = 1'b0;
    end
    push(sel, oh, d, act, rdy, lst, nm);
  endtask

  initial begin
    rst = 1'b1;
    v4 = 0; c4 = 0; e4 = 1; a4 = 0;
    v1 = 0; c1 = 0; e1 = 1; a1 = 0;

    cyc(0, 0, 0, 1, 0, 8'h00, 0, 0, 1, 0, "reset4");
    cyc(1, 0, 0, 1, 0, 8'h00, 0, 0, 1, 0, "reset1");
    rst = 1'b0;

    // Basic: code 5 held for 4 cycles, then done pulse
    cyc(0, 1, 5, 1, 0, 8'h00, 0, 0, 1, 0, "basic_acc");
    cyc(0, 0, 0, 1, 0, 8'h20, 0, 1, 0, 5, "basic_h1");
    cyc(0, 0, 0, 1, 0, 8'h20, 0, 1, 0, 5, "basic_h2");
    cyc(0, 0, 0, 1, 0, 8'h20, 0, 1, 0, 5, "basic_h3");
    cyc(0, 0, 0, 1, 0, 8'h20, 0, 1, 1, 5, "basic_h4");
    cyc(0, 0, 0, 1, 0, 8'h00, 1, 0, 1, 5, "basic_done");
    cyc(0, 0, 0, 1, 0, 8'h00, 0, 0, 1, 5, "basic_idle");

    // Back-to-back: code 0 then 7 with no gap
    cyc(0, 1, 0, 1, 0, 8'h00, 0, 0, 1, 5, "b2b_acc0");
    cyc(0, 1, 7, 1, 0, 8'h01, 0, 1, 0, 0, "b2b_a1");
    cyc(0, 1, 7, 1, 0, 8'h01, 0, 1, 0, 0, "b2b_a2");
    cyc(0, 1, 7, 1, 0, 8'h01, 0, 1, 0, 0, "b2b_a3");
    cyc(0, 1, 7, 1, 0, 8'h01, 0, 1, 1, 0, "b2b_a4");
    cyc(0, 0, 0, 1, 0, 8'h80, 1, 1, 0, 7, "b2b_b1");
    cyc(0, 0, 0, 1, 0, 8'h80, 0, 1, 0, 7, "b2b_b2");
    cyc(0, 0, 0, 1, 0, 8'h80, 0, 1, 0, 7, "b2b_b3");
    cyc(0, 0, 0, 1, 0, 8'h80, 0, 1, 1, 7, "b2b_b4");
    cyc(0, 0, 0, 1, 0, 8'h00, 1, 0, 1, 7, "b2b_done");

    // Pause: code 2, 2 grant cycles, 3 paused, 2 more
    cyc(0, 1, 2, 1, 0, 8'h00, 0, 0, 1, 7, "pause_acc");
    cyc(0, 0, 0, 1, 0, 8'h04, 0, 1, 0, 2, "pause_g1");
    cyc(0, 0, 0, 1, 0, 8'h04, 0, 1, 0, 2, "pause_g2");
    cyc(0, 0, 0, 0, 0, 8'h00, 0, 1, 0, 2, "pause_p1");
    cyc(0, 0, 0, 0, 0, 8'h00, 0, 1, 0, 2, "pause_p2");
    cyc(0, 0, 0, 0, 0, 8'h00, 0, 1, 0, 2, "pause_p3");
    cyc(0, 0, 0, 1, 0, 8'h04, 0, 1, 0, 2, "pause_g3");
    cyc(0, 0, 0, 1, 0, 8'h04, 0, 1, 1, 2, "pause_g4");
    cyc(0, 0, 0, 1, 0, 8'h00, 1, 0, 1, 2, "pause_done");

    // Abort on the counter==0 cycle while code 6 waits
    cyc(0, 1, 3, 1, 0, 8'h00, 0, 0, 1, 2, "abort_acc");
    cyc(0, 1, 6, 1, 0, 8'h08, 0, 1, 0, 3, "abort_h1");
    cyc(0, 1, 6, 1, 0, 8'h08, 0, 1, 0, 3, "abort_h2");
    cyc(0, 1, 6, 1, 0, 8'h08, 0, 1, 0, 3, "abort_h3");
    cyc(0, 1, 6, 1, 1, 8'h08, 0, 1, 0, 3, "abort_last");
    cyc(0, 1, 6, 1, 0, 8'h00, 0, 0, 1, 3, "abort_idle");
    cyc(0, 0, 0, 1, 0, 8'h40, 0, 1, 0, 6, "abort_new");
    cyc(0, 0, 0, 0, 1, 8'h00, 0, 1, 0, 6, "abort_paused");
    // Abort in IDLE is ignored and the code is accepted
    cyc(0, 1, 4, 1, 1, 8'h00, 0, 0, 1, 6, "abort_idle_acc");
    cyc(0, 0, 0, 1, 0, 8'h10, 0, 1, 0, 4, "rst_g1");
    cyc(0, 0, 0, 1, 0, 8'h10, 0, 1, 0, 4, "rst_g2");

    // Async reset between edges mid-grant
    @(posedge clk);
    #1;
    v4 = 0; e4 = 1; a4 = 0;
    #1 rst = 1'b1;
    push(0, 8'h00, 0, 0, 1, 0, "rst_async");
    cyc(0, 0, 0, 1, 0, 8'h00, 0, 0, 1, 0, "rst_held");
    rst = 1'b0;
    cyc(0, 0, 0, 1, 0, 8'h00, 0, 0, 1, 0, "rst_after1");
    cyc(0, 0, 0, 1, 0, 8'h00, 0, 0, 1, 0, "rst_after2");

    // HOLD_CYCLES=1 sweep: one grant per cycle, done on 8 consecutive cycles
    for (int k = 0; k <= 7; k++) begin
      logic [7:0] oh;
      logic [2:0] lst;
      logic [2:0] cd;
      cd  = 3'(k);
      oh  = (k == 0) ? 8'h00 : (8'(1) << (k - 1));
      lst = (k == 0) ? 3'd0 : 3'(k - 1);
      cyc(1, 1, cd, 1, 0, oh, (k >= 2), (k >= 1), 1, lst, "sweep");
    end
    cyc(1, 0, 0, 1, 0, 8'h80, 1, 1, 1, 7, "sweep_last");
    cyc(1, 0, 0, 1, 0, 8'h00, 1, 0, 1, 7, "sweep_done");
    cyc(1, 0, 0, 1, 0, 8'h00, 0, 0, 1, 7, "sweep_idle");

    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      checks++;
      $display("FAIL drain: got %0d pending, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
